// File: rtl/cook_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cook_timer
// Microwave cook-time countdown. Holds the remaining time as BCD MM:SS and
// counts it down once per second while cooking. It drives the magnetron enable,
// the done buzzer and the display digits.
//
// Parameters
//   BEEP_SECS  seconds the buzzer stays on after the countdown ends (1..15)
//   MAX_MIN    minute value that larger load requests are clamped to (<= 99)
//
// Ports
//   sys_clk    system clock, shared with the seconds divider
//   reset_n    asynchronous active-low reset
//   clk_1s     1 Hz square wave, sampled as a level and synchronised here
//   load       one-cycle pulse: capture min_in / sec_in (IDLE and PAUSE only)
//   min_in     binary minutes, clamped to MAX_MIN
//   sec_in     binary seconds, clamped to 59
//   start      one-cycle pulse: begin or resume cooking
//   stop       one-cycle pulse: pause cooking
//   clear      one-cycle pulse: abort and zero the time
//   door_open  level, 1 = door open (already synchronous to sys_clk)
//   min_tens, min_ones, sec_tens, sec_ones   BCD display digits
//   heating    magnetron enable
//   done_beep  buzzer enable
//   state      encoded FSM state for debug (IDLE=0 COOK=1 PAUSE=2 DONE=3)
// -----------------------------------------------------------------------------
module cook_timer #(
  parameter int unsigned BEEP_SECS = 3,
  parameter int unsigned MAX_MIN   = 99
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       clk_1s,
  input  logic       load,
  input  logic [6:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heating,
  output logic       done_beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COOK  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  localparam bcd_time_t ZERO_TIME = '0;

  state_t    state_q, state_next;
  bcd_time_t time_q, time_next;
  logic [3:0] beep_cnt_q, beep_cnt_next;

  // ---------------------------------------------------------------------------
  // Seconds tick: two-flop synchroniser, a delayed copy for edge detection and
  // a registered one-cycle pulse. The pulse is high after the third sys_clk
  // edge following the clk_1s rise.
  // ---------------------------------------------------------------------------
  logic sync_q1, sync_q2, sync_q3, tick;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, as real flops do.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_q1 <= clk_1s;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
      tick    <= sync_q2 & ~sync_q3;
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: clamp the binary request, then split it into BCD digits.
  // ---------------------------------------------------------------------------
  logic [6:0] ld_min;
  logic [5:0] ld_sec;
  bcd_time_t  ld_time;

  always_comb begin
    ld_min           = (min_in > 7'(MAX_MIN)) ? 7'(MAX_MIN) : min_in;
    ld_sec           = (sec_in > 6'd59) ? 6'd59 : sec_in;
    ld_time.min_tens = 4'(ld_min / 7'd10);
    ld_time.min_ones = 4'(ld_min % 7'd10);
    ld_time.sec_tens = 4'(ld_sec / 6'd10);
    ld_time.sec_ones = 4'(ld_sec % 6'd10);
  end

  // ---------------------------------------------------------------------------
  // One-second BCD decrement with borrow chain. Only used when the time is
  // above 00:01, so the minute-tens digit never underflows.
  // ---------------------------------------------------------------------------
  bcd_time_t dec_time;
  logic      time_zero, time_one;

  // NOTE: every signal assigned in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    dec_time = time_q;
    if (time_q.sec_ones != 4'd0) begin
      dec_time.sec_ones = time_q.sec_ones - 4'd1;
    end else begin
      dec_time.sec_ones = 4'd9;
      if (time_q.sec_tens != 4'd0) begin
        dec_time.sec_tens = time_q.sec_tens - 4'd1;
      end else begin
        dec_time.sec_tens = 4'd5;
        if (time_q.min_ones != 4'd0) begin
          dec_time.min_ones = time_q.min_ones - 4'd1;
        end else begin
          dec_time.min_ones = 4'd9;
          dec_time.min_tens = time_q.min_tens - 4'd1;
        end
      end
    end
  end

  assign time_zero = (time_q == ZERO_TIME);
  assign time_one  = (time_q == bcd_time_t'({4'd0, 4'd0, 4'd0, 4'd1}));

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: clear > door_open > stop > start > load > tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_q;
    time_next     = time_q;
    beep_cnt_next = beep_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (clear) begin
          time_next = ZERO_TIME;
        end else if (start && !door_open && !time_zero) begin
          state_next = ST_COOK;
        end else if (load) begin
          time_next = ld_time;
        end
      end

      ST_COOK: begin
        if (clear) begin
          state_next = ST_IDLE;
          time_next  = ZERO_TIME;
        end else if (door_open || stop) begin
          state_next = ST_PAUSE;
        end else if (tick) begin
          // A zero time can reach COOK through a PAUSE reload; finish it
          // rather than wrapping the digits.
          if (time_one || time_zero) begin
            state_next    = ST_DONE;
            time_next     = ZERO_TIME;
            beep_cnt_next = 4'd0;
          end else begin
            time_next = dec_time;
          end
        end
      end

      ST_PAUSE: begin
        if (clear) begin
          state_next = ST_IDLE;
          time_next  = ZERO_TIME;
        end else if (start && !door_open) begin
          state_next = ST_COOK;
        end else if (load) begin
          time_next = ld_time;
        end
      end

      ST_DONE: begin
        if (clear || door_open) begin
          state_next    = ST_IDLE;
          time_next     = ZERO_TIME;
          beep_cnt_next = 4'd0;
        end else if (tick) begin
          if (beep_cnt_q == 4'(BEEP_SECS - 1)) begin
            state_next    = ST_IDLE;
            beep_cnt_next = 4'd0;
          end else begin
            beep_cnt_next = beep_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_next    = ST_IDLE;
        time_next     = ZERO_TIME;
        beep_cnt_next = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, time and output registers. heating and done_beep are registered
  // from the next state so they switch on the same edge as the state itself,
  // which drops heating one cycle after the door is seen open.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      time_q     <= ZERO_TIME;
      beep_cnt_q <= 4'd0;
      heating    <= 1'b0;
      done_beep  <= 1'b0;
    end else begin
      state_q    <= state_next;
      time_q     <= time_next;
      beep_cnt_q <= beep_cnt_next;
      heating    <= (state_next == ST_COOK);
      done_beep  <= (state_next == ST_DONE);
    end
  end

  assign min_tens = time_q.min_tens;
  assign min_ones = time_q.min_ones;
  assign sec_tens = time_q.sec_tens;
  assign sec_ones = time_q.sec_ones;
  assign state    = state_q;

endmodule
